// File: rtl/mii_tx_arbiter.sv
// Two-source transmit frame arbiter feeding one MII encoder: round-robin per whole frame,
// runt padding to MIN_LEN, inter-frame gap enforcement and clean abort on source underrun.
module mii_tx_arbiter #(
  parameter int MIN_LEN   = 60,
  parameter int IFG_BYTES = 12,
  parameter int CNT_W     = 11
) (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic        i_req0_valid,
  input  logic [7:0]  i_req0_data,
  input  logic        i_req0_last,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [7:0]  i_req1_data,
  input  logic        i_req1_last,
  output logic        o_req1_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic        o_underrun,
  output logic [15:0] o_frames
);

  typedef enum logic [2:0] {IDLE, SEND, PAD, GAP, DRAIN} state_t;

  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(MIN_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [1:0]       grant_n;
  logic             last_grant, last_grant_n;
  logic [CNT_W-1:0] count, count_n;
  logic             tx_en_n;
  logic [7:0]       tx_data_n;
  logic [15:0]      frames_n;
  logic             underrun_n;
  logic             aborted, aborted_n;

  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;

  assign sel_valid = o_grant[1] ? i_req1_valid : i_req0_valid;
  assign sel_last  = o_grant[1] ? i_req1_last  : i_req0_last;
  assign sel_data  = o_grant[1] ? i_req1_data  : i_req0_data;

  // Draining ignores the encoder so an aborted frame is flushed at source speed.
  assign o_req0_ready = o_grant[0] & (((state == SEND) & tx_ready) | (state == DRAIN));
  assign o_req1_ready = o_grant[1] & (((state == SEND) & tx_ready) | (state == DRAIN));
  assign o_busy       = (state != IDLE);

  always_comb begin
    state_n      = state;
    grant_n      = o_grant;
    last_grant_n = last_grant;
    count_n      = count;
    tx_en_n      = tx_en;
    tx_data_n    = tx_data;
    frames_n     = o_frames;
    underrun_n   = 1'b0;
    aborted_n    = aborted;
    case (state)
      IDLE: begin
        grant_n   = 2'b00;
        count_n   = '0;
        aborted_n = 1'b0;
        if (i_req0_valid && (!i_req1_valid || last_grant)) begin
          grant_n      = 2'b01;
          last_grant_n = 1'b0;
          state_n      = SEND;
        end else if (i_req1_valid) begin
          grant_n      = 2'b10;
          last_grant_n = 1'b1;
          state_n      = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (sel_valid) begin
            tx_en_n   = 1'b1;
            tx_data_n = sel_data;
            if (count != MIN_CNT) count_n = count + CNT_ONE;
            if (sel_last) begin
              if (count < PAD_LAST) begin
                state_n = PAD;
              end else begin
                state_n = GAP;
                count_n = '0;
              end
            end
          end else begin
            tx_en_n    = 1'b0;
            underrun_n = 1'b1;
            aborted_n  = 1'b1;
            state_n    = DRAIN;
          end
        end
      end
      PAD: begin
        if (tx_ready) begin
          tx_en_n   = 1'b1;
          tx_data_n = 8'h00;
          if (count == PAD_LAST) begin
            state_n = GAP;
            count_n = '0;
          end else begin
            count_n = count + CNT_ONE;
          end
        end
      end
      GAP: begin
        // count restarts at zero on entry, so zero marks the slot that closes the frame
        if (tx_ready) begin
          tx_en_n = 1'b0;
          if ((count == '0) && !aborted) frames_n = o_frames + 16'd1;
          if (count == GAP_LAST) begin
            state_n = IDLE;
            grant_n = 2'b00;
            count_n = '0;
          end else begin
            count_n = count + CNT_ONE;
          end
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) begin
          state_n = GAP;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      state      <= IDLE;
      o_grant    <= 2'b00;
      last_grant <= 1'b1;
      count      <= '0;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      o_frames   <= 16'd0;
      o_underrun <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_n;
      o_grant    <= grant_n;
      last_grant <= last_grant_n;
      count      <= count_n;
      tx_en      <= tx_en_n;
      tx_data    <= tx_data_n;
      o_frames   <= frames_n;
      o_underrun <= underrun_n;
      aborted    <= aborted_n;
    end
  end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Bench for mii_tx_arbiter: queue-driven sources, slot-level capture of the encoder stream,
// and frame-level expectations (padding, gaps, grant order) checked per scenario.
module tb_mii_tx_arbiter;
  localparam int MIN_LEN = 60;
  localparam int IFG     = 12;

  logic        clk = 1'b0;
  logic        nreset;
  logic        v0, l0, r0, v1, l1, r1;
  logic [7:0]  d0, d1;
  logic        tx_en, tx_ready;
  logic [7:0]  tx_data;
  logic [1:0]  grant;
  logic        busy, underrun;
  logic [15:0] frames;

  always #5 clk = ~clk;

  mii_tx_arbiter #(.MIN_LEN(MIN_LEN), .IFG_BYTES(IFG), .CNT_W(11)) dut (
    .i_clk(clk), .i_nreset(nreset),
    .i_req0_valid(v0), .i_req0_data(d0), .i_req0_last(l0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_data(d1), .i_req1_last(l1), .o_req1_ready(r1),
    .tx_en(tx_en), .tx_data(tx_data), .tx_ready(tx_ready),
    .o_grant(grant), .o_busy(busy), .o_underrun(underrun), .o_frames(frames)
  );

  int passed = 0;
  int total  = 0;

  logic [8:0] sq0[$];
  logic [8:0] sq1[$];
  logic       hold0 = 1'b0;
  int         rdy_mode = 0;

  logic       slot_en[$];
  logic [7:0] slot_data[$];
  logic [1:0] grant_log[$];
  logic [1:0] prev_grant;
  logic       busy_s;
  int cyc = 0;
  int under_cnt, viol, acc0_cnt, acc1_cnt, grant_cyc, txen_cyc;
  int run_start[$], run_len[$], gap_after[$];

  task automatic step();
    logic a0, a1;
    @(negedge clk);
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    v0 = 1'b0; d0 = 8'h00; l0 = 1'b0;
    v1 = 1'b0; d1 = 8'h00; l1 = 1'b0;
    if (sq0.size() > 0) begin
      v0 = !hold0; d0 = sq0[0][7:0]; l0 = sq0[0][8];
    end
    if (sq1.size() > 0) begin
      v1 = 1'b1; d1 = sq1[0][7:0]; l1 = sq1[0][8];
    end
    #1;
    if (tx_ready) begin
      slot_en.push_back(tx_en);
      slot_data.push_back(tx_data);
    end
    a0 = v0 && r0;
    a1 = v1 && r1;
    if (r0 && grant != 2'b01) viol++;
    if (r1 && grant != 2'b10) viol++;
    if (underrun) under_cnt++;
    if (grant != 2'b00 && grant != prev_grant) grant_log.push_back(grant);
    prev_grant = grant;
    if (grant != 2'b00 && grant_cyc < 0) grant_cyc = cyc;
    if (tx_en && txen_cyc < 0) txen_cyc = cyc;
    busy_s = busy;
    @(posedge clk);
    if (a0) begin void'(sq0.pop_front()); acc0_cnt++; end
    if (a1) begin void'(sq1.pop_front()); acc1_cnt++; end
    cyc++;
  endtask

  task automatic clear_logs();
    slot_en.delete(); slot_data.delete(); grant_log.delete();
    prev_grant = 2'b00;
    under_cnt = 0; viol = 0; acc0_cnt = 0; acc1_cnt = 0;
    grant_cyc = -1; txen_cyc = -1;
  endtask

  task automatic run_idle(input int budget, output bit timed_out);
    int n = 0;
    do begin
      step();
      n++;
    end while ((sq0.size() > 0 || sq1.size() > 0 || busy_s) && n < budget);
    timed_out = (sq0.size() > 0 || sq1.size() > 0 || busy_s);
    repeat (20) step();
  endtask

  // Split the captured slot stream into high runs (frames) and the low slots after each.
  task automatic parse_runs();
    int i, s, n;
    run_start.delete(); run_len.delete(); gap_after.delete();
    n = slot_en.size();
    i = 0;
    while (i < n) begin
      if (slot_en[i] === 1'b1) begin
        s = i;
        while (i < n && slot_en[i] === 1'b1) i++;
        run_start.push_back(s);
        run_len.push_back(i - s);
        s = i;
        while (i < n && slot_en[i] !== 1'b1) i++;
        gap_after.push_back(i - s);
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    clear_logs();
    repeat (3) step();
    #1;
    total++; if (tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b want 0", tx_en); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
    total++; if (frames !== 16'd0) $display("FAIL reset_frames: got %0d want 0", frames); else passed++;
    total++; if (r0 !== 1'b0 || r1 !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", r1, r0); else passed++;
    nreset = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [7:0] f[$];
    bit to;
    int errs = 0;
    clear_logs();
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      f.push_back(8'($urandom));
      sq0.push_back({(i == 59), f[i]});
    end
    run_idle(2000, to);
    total++; if (to) $display("FAIL single_timeout: still busy got 1 want 0"); else passed++;
    parse_runs();
    total++;
    if (run_len.size() != 1 || run_len[0] != 60)
      $display("FAIL single_len: got %0d runs (first %0d) want 1 run of 60", run_len.size(), (run_len.size() > 0) ? run_len[0] : 0);
    else passed++;
    if (run_len.size() > 0)
      for (int j = 0; j < 60 && j < run_len[0]; j++)
        if (slot_data[run_start[0] + j] !== f[j]) errs++;
    total++; if (run_len.size() == 0 || errs != 0) $display("FAIL single_bytes: got %0d byte errors want 0", errs); else passed++;
    total++;
    if (gap_after.size() == 0 || gap_after[0] < IFG)
      $display("FAIL single_gap: got %0d idle slots want >= %0d", (gap_after.size() > 0) ? gap_after[0] : 0, IFG);
    else passed++;
    total++; if (frames !== 16'd1) $display("FAIL single_frames: got %0d want 1", frames); else passed++;
  endtask

  task automatic test_runt();
    bit to;
    int c0, errs = 0;
    logic [7:0] want;
    clear_logs();
    rdy_mode = 0;
    c0 = cyc;
    for (int i = 1; i <= 20; i++) sq1.push_back({(i == 20), 8'(i)});
    run_idle(2000, to);
    total++; if (to) $display("FAIL runt_timeout: still busy got 1 want 0"); else passed++;
    total++; if (grant_cyc != c0 + 1) $display("FAIL runt_grant_latency: got cycle %0d want %0d", grant_cyc, c0 + 1); else passed++;
    total++; if (txen_cyc != c0 + 2) $display("FAIL runt_txen_latency: got cycle %0d want %0d", txen_cyc, c0 + 2); else passed++;
    parse_runs();
    total++;
    if (run_len.size() != 1 || run_len[0] != MIN_LEN)
      $display("FAIL runt_len: got %0d runs (first %0d) want 1 run of %0d", run_len.size(), (run_len.size() > 0) ? run_len[0] : 0, MIN_LEN);
    else passed++;
    if (run_len.size() > 0)
      for (int j = 0; j < MIN_LEN && j < run_len[0]; j++) begin
        want = (j < 20) ? 8'(j + 1) : 8'h00;
        if (slot_data[run_start[0] + j] !== want) errs++;
      end
    total++; if (run_len.size() == 0 || errs != 0) $display("FAIL runt_bytes: got %0d byte errors want 0", errs); else passed++;
    total++;
    if (gap_after.size() == 0 || gap_after[0] < IFG)
      $display("FAIL runt_gap: got %0d idle slots want >= %0d", (gap_after.size() > 0) ? gap_after[0] : 0, IFG);
    else passed++;
    total++; if (frames !== 16'd2) $display("FAIL runt_frames: got %0d want 2", frames); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] fr[2][3][64];
    bit to;
    int errs, src, idx, gap_errs = 0, order_errs = 0;
    clear_logs();
    rdy_mode = 0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 64; j++) begin
        fr[0][k][j] = 8'($urandom);
        fr[1][k][j] = 8'($urandom);
        sq0.push_back({(j == 63), fr[0][k][j]});
        sq1.push_back({(j == 63), fr[1][k][j]});
      end
    run_idle(4000, to);
    total++; if (to) $display("FAIL rr_timeout: still busy got 1 want 0"); else passed++;
    total++;
    if (grant_log.size() != 6) $display("FAIL rr_grant_count: got %0d grants want 6", grant_log.size());
    else begin
      for (int i = 0; i < 6; i++)
        if (grant_log[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) order_errs++;
      if (order_errs != 0) $display("FAIL rr_grant_order: got %0d out-of-order grants want 0", order_errs);
      else passed++;
    end
    parse_runs();
    total++;
    if (run_len.size() != 6) $display("FAIL rr_runs: got %0d frames want 6", run_len.size());
    else passed++;
    for (int i = 0; i < 6 && i < run_len.size(); i++) begin
      src = i % 2; idx = i / 2; errs = 0;
      for (int j = 0; j < 64 && j < run_len[i]; j++)
        if (slot_data[run_start[i] + j] !== fr[src][idx][j]) errs++;
      total++;
      if (run_len[i] != 64 || errs != 0)
        $display("FAIL rr_frame%0d: got len %0d with %0d byte errors want len 64 exact", i, run_len[i], errs);
      else passed++;
    end
    // Back-to-back: IFG low slots plus the IDLE arbitration and first-accept slots.
    for (int i = 0; i < 5 && i < gap_after.size(); i++)
      if (gap_after[i] != IFG + 1) gap_errs++;
    total++; if (gap_errs != 0 || gap_after.size() < 5) $display("FAIL rr_gaps: got %0d wrong gaps want 0", gap_errs); else passed++;
    total++; if (viol != 0) $display("FAIL rr_ungranted_ready: got %0d want 0", viol); else passed++;
    total++; if (frames !== 16'd8) $display("FAIL rr_frames: got %0d want 8", frames); else passed++;
  endtask

  task automatic test_underrun();
    logic [7:0] f[$];
    bit to;
    int n, drain_cyc, errs = 0;
    logic [15:0] frames0;
    clear_logs();
    rdy_mode = 0;
    frames0 = frames;
    for (int i = 0; i < 40; i++) begin
      f.push_back(8'($urandom));
      sq0.push_back({(i == 39), f[i]});
    end
    n = 0;
    while (acc0_cnt < 10 && n < 200) begin step(); n++; end
    total++; if (acc0_cnt != 10) $display("FAIL ur_accept: got %0d bytes want 10", acc0_cnt); else passed++;
    hold0 = 1'b1;
    repeat (5) step();
    hold0 = 1'b0;
    rdy_mode = 2;
    drain_cyc = 0;
    while (sq0.size() > 0 && drain_cyc < 200) begin step(); drain_cyc++; end
    total++; if (drain_cyc != 30) $display("FAIL ur_drain_cycles: got %0d want 30", drain_cyc); else passed++;
    run_idle(1000, to);
    total++; if (to) $display("FAIL ur_timeout: still busy got 1 want 0"); else passed++;
    total++; if (under_cnt != 1) $display("FAIL ur_pulse: got %0d high cycles want 1", under_cnt); else passed++;
    parse_runs();
    if (run_len.size() > 0)
      for (int j = 0; j < 10 && j < run_len[0]; j++)
        if (slot_data[run_start[0] + j] !== f[j]) errs++;
    total++;
    if (run_len.size() != 1 || run_len[0] != 10 || errs != 0)
      $display("FAIL ur_stream: got %0d runs (first %0d, %0d byte errors) want 1 run of 10", run_len.size(), (run_len.size() > 0) ? run_len[0] : 0, errs);
    else passed++;
    total++;
    if (gap_after.size() == 0 || gap_after[0] < IFG)
      $display("FAIL ur_gap: got %0d idle slots want >= %0d", (gap_after.size() > 0) ? gap_after[0] : 0, IFG);
    else passed++;
    total++; if (frames !== frames0) $display("FAIL ur_frames: got %0d want %0d", frames, frames0); else passed++;
    total++; if (viol != 0) $display("FAIL ur_ungranted_ready: got %0d want 0", viol); else passed++;
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    clear_logs();
    rdy_mode = 0;
    for (int j = 0; j < 64; j++) begin
      sq0.push_back({(j == 63), 8'($urandom)});
      sq1.push_back({(j == 63), 8'($urandom)});
    end
    // Source 0 was granted last, so source 1 owns this frame when reset hits.
    n = 0;
    while (acc1_cnt < 30 && n < 300) begin step(); n++; end
    total++; if (acc1_cnt != 30 || tx_en !== 1'b1) $display("FAIL rm_midframe: got %0d bytes tx_en %b want 30 and 1", acc1_cnt, tx_en); else passed++;
    nreset = 1'b0;
    step();
    #1;
    total++; if (tx_en !== 1'b0) $display("FAIL rm_tx_en: got %b want 0", tx_en); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL rm_tx_data: got %h want 00", tx_data); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL rm_grant: got %b want 00", grant); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passed++;
    total++; if (frames !== 16'd0) $display("FAIL rm_frames: got %0d want 0", frames); else passed++;
    total++; if (r1 !== 1'b0) $display("FAIL rm_ready1: got %b want 0", r1); else passed++;
    nreset = 1'b1;
    grant_log.delete();
    prev_grant = 2'b00;
    repeat (3) step();
    total++;
    if (grant_log.size() == 0 || grant_log[0] !== 2'b01)
      $display("FAIL rm_next_grant: got %b want 01", (grant_log.size() > 0) ? grant_log[0] : 2'b00);
    else passed++;
    run_idle(3000, to);
    total++; if (to) $display("FAIL rm_timeout: still busy got 1 want 0"); else passed++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; tx_ready = 1'b0;
    v0 = 1'b0; d0 = 8'h00; l0 = 1'b0;
    v1 = 1'b0; d1 = 8'h00; l1 = 1'b0;
    busy_s = 1'b0;
    test_reset();
    test_single_frame();
    test_runt();
    test_round_robin();
    test_underrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
